// File: rtl/spike_event_scheduler.sv
// spike_event_scheduler: queues spike events and sequences the synapse selector one event at a time
module spike_event_scheduler #(
   parameter int PRE_W      = 8,
   parameter int POST_W     = 8,
   parameter int ADDR_W     = 12,
   parameter int WEIGHT_W   = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int TIMEOUT    = 1023
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                spike_valid_i,
   input  logic [PRE_W-1:0]    spike_pre_i,
   output logic                spike_ready_o,
   input  logic                cfg_load_i,
   input  logic [POST_W-1:0]   cfg_postsyn_count_i,
   input  logic [ADDR_W-1:0]   cfg_weights_base_i,
   input  logic                step_end_i,
   output logic                sel_start_o,
   output logic [PRE_W-1:0]    sel_preidx_o,
   output logic [POST_W-1:0]   sel_postsyn_count_o,
   output logic [ADDR_W-1:0]   sel_weights_base_o,
   input  logic                sel_busy_i,
   input  logic                sel_done_i,
   input  logic                sel_valid_i,
   input  logic [POST_W-1:0]   sel_postidx_i,
   input  logic [WEIGHT_W-1:0] sel_weight_i,
   output logic                syn_valid_o,
   output logic [PRE_W-1:0]    syn_pre_o,
   output logic [POST_W-1:0]   syn_post_o,
   output logic [WEIGHT_W-1:0] syn_weight_o,
   output logic                step_done_o,
   output logic                idle_o,
   output logic                err_timeout_o,
   output logic [15:0]         drop_cnt_o,
   output logic [15:0]         event_cnt_o
);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]         state;
   logic [PRE_W-1:0]   mem [FIFO_DEPTH];
   logic [PW:0]        wr_ptr, rd_ptr;
   logic               full, empty, push, pop, is_idle, in_wait;
   logic               pend_flag, step_pend;
   logic [POST_W-1:0]  pend_count, eff_count;
   logic [ADDR_W-1:0]  pend_base;
   logic [WD_W-1:0]    wd;
   logic               unused;

   assign unused        = sel_busy_i;
   assign full          = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign empty         = wr_ptr == rd_ptr;
   assign push          = spike_valid_i && !full;
   assign is_idle       = state == S_IDLE;
   assign in_wait       = state == S_WAIT;
   assign pop           = is_idle && !empty;
   // pending config is applied in the same IDLE cycle that may pop, so decide on it directly
   assign eff_count     = pend_flag ? pend_count : sel_postsyn_count_o;
   assign spike_ready_o = !full;
   assign idle_o        = is_idle && empty;
   assign sel_start_o   = state == S_ISSUE;
   assign step_done_o   = step_pend && idle_o;

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr[PW-1:0]] <= spike_pre_i;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state               <= S_IDLE;
         wr_ptr              <= '0;
         rd_ptr              <= '0;
         pend_flag           <= 1'b0;
         pend_count          <= '0;
         pend_base           <= '0;
         step_pend           <= 1'b0;
         wd                  <= '0;
         sel_preidx_o        <= '0;
         sel_postsyn_count_o <= '0;
         sel_weights_base_o  <= '0;
         syn_valid_o         <= 1'b0;
         syn_pre_o           <= '0;
         syn_post_o          <= '0;
         syn_weight_o        <= '0;
         err_timeout_o       <= 1'b0;
         drop_cnt_o          <= '0;
         event_cnt_o         <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (spike_valid_i && full && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
         if (cfg_load_i) begin
            pend_flag  <= 1'b1;
            pend_count <= cfg_postsyn_count_i;
            pend_base  <= cfg_weights_base_i;
         end else if (is_idle) begin
            pend_flag <= 1'b0;
         end
         if (is_idle && pend_flag) begin
            sel_postsyn_count_o <= pend_count;
            sel_weights_base_o  <= pend_base;
         end
         step_pend <= (step_pend || step_end_i) && !step_done_o;
         if (pop) begin
            rd_ptr <= rd_ptr + (PW+1)'(1);
            if (eff_count == '0) begin
               event_cnt_o <= event_cnt_o + 16'd1;
            end else begin
               sel_preidx_o <= mem[rd_ptr[PW-1:0]];
               state        <= S_ISSUE;
            end
         end
         if (state == S_ISSUE) begin
            state <= S_WAIT;
            wd    <= '0;
         end
         if (in_wait) begin
            if (sel_done_i) begin
               event_cnt_o <= event_cnt_o + 16'd1;
               state       <= S_IDLE;
            end else if (wd == WD_LAST) begin
               err_timeout_o <= 1'b1;
               state         <= S_IDLE;
            end else begin
               wd <= wd + WD_W'(1);
            end
         end
         syn_valid_o <= in_wait && sel_valid_i;
         if (in_wait && sel_valid_i) begin
            syn_pre_o    <= sel_preidx_o;
            syn_post_o   <= sel_postidx_i;
            syn_weight_o <= sel_weight_i;
         end
      end
   end
endmodule
